pwm_duty_sched: RTL
===================

Name: pwm_duty_sched

Overview:
Arbitrates duty-cycle change requests from several requesters and drives the 8-bit duty_cycle input of one shared pwm generator. Requests are accepted with a valid/ready handshake. Each accepted target is reached by a slew-limited ramp: duty_cycle steps by at most STEP once per PWM period, so the pwm never sees an abrupt jump. The block sits between control logic (e.g. motor/LED controllers) and the pwm instance, and runs on the same clk/clr.

Parameters:
NREQ, 2, number of requesters (1..8)
PERIOD_CLKS, 256, clocks per PWM period; the internal period tick fires once per PERIOD_CLKS clocks (>=2)
STEP, 1, maximum duty_cycle change per period tick (1..255)

Ports:
clk  input  1  system clock; all state changes on posedge clk
clr  input  1  reset, synchronous, active-high
req_valid  input  NREQ  requester i presents a target
req_duty  input  8*NREQ  target duty for requester i, in bits [8i+7:8i]
req_ready  output  NREQ  one-hot grant; transfer when req_valid[i] & req_ready[i]
duty_cycle  output  8  registered duty value to the pwm
busy  output  1  ramp in progress
done  output  1  one-cycle pulse when duty_cycle reaches the target
grant_id  output  $clog2(NREQ) (min 1)  index of the last accepted requester
tick  output  1  one-cycle pulse on the last clock of each period

Behaviour:
- Reset (clr=1 at posedge) clears duty_cycle, busy, done, grant_id, target, period counter and rr pointer to 0. Clear takes effect on the next cycle, including mid-ramp. req_ready is 0 while clr=1.
- Period counter: width $clog2(PERIOD_CLKS). Counts 0..PERIOD_CLKS-1 and wraps. Free-running; it does not restart on request acceptance. tick=1 when count==PERIOD_CLKS-1.
- States: IDLE, RAMP.
- IDLE: req_ready is combinational, at most one bit set. It grants the first valid requester scanning from rr pointer upward modulo NREQ. If no requester is valid, req_ready=0.
- On transfer in IDLE:
  - latch target, set grant_id to i, set rr pointer to (i+1) mod NREQ.
  - If target != duty_cycle, go to RAMP and set busy=1 next cycle.
  - If target == duty_cycle, stay in IDLE and pulse done next cycle.
- RAMP: req_ready=0; requests are held off and requesters keep valid asserted. On each tick cycle duty_cycle is updated:
  - rising: duty_cycle + min(STEP, target-duty_cycle)
  - falling: duty_cycle - min(STEP, duty_cycle-target)
  - The difference is computed 9-bit unsigned, so duty_cycle never wraps past 0 or 255.
  - The new value is visible the cycle after tick, i.e. it is aligned with the start of a period.
- When the updated duty_cycle equals target: go to IDLE, busy=0, done=1 for exactly that same cycle. Arbitration resumes in that cycle.
- Ramp length = ceil(|target-start|/STEP) ticks. Worst case STEP=1, 0->255: 255 periods.
- Simultaneous clr and transfer/tick: clr wins.

Optional Feature:
- Macro PWM_SCHED_FIXED_PRIO_EN.
- Defined: fixed priority, lowest set index of req_valid wins. The rr pointer is not implemented.
- Undefined: round-robin as above.
- All other behaviour is identical in both builds.

Test Plan:
- Reset: clr held 2 cycles with req_valid=2'b11 -> req_ready=0. Then duty_cycle=0, busy=0, done=0, grant_id=0.
- Ramp up: PERIOD_CLKS=16, STEP=1, req 0 target 4 -> accepted in 1 cycle. duty_cycle=1,2,3,4 on the cycles after 4 successive ticks. done pulses once with duty=4, then busy=0.
- Clamped step: STEP=3, start 0, target 10 -> sequence 3,6,9,10. Then a target 1 request -> sequence 7,4,1. No underflow.
- Equal target: duty=10, request 10 -> no RAMP entry, busy stays 0, done pulses the cycle after the transfer.
- Contention (round-robin): both requesters valid continuously with alternating targets 20/40 -> grants 0,1,0,1. req_ready is never asserted during RAMP. With PWM_SCHED_FIXED_PRIO_EN -> grants 0,0,0.
- Mid-ramp clear: clr=1 while busy and duty=5 -> next cycle duty_cycle=0, busy=0, no done pulse. The next request is accepted by requester 0 first.

Source files
------------

// File: rtl/pwm_duty_sched.sv
`default_nettype none
// ============================================================================
// Module  : pwm_duty_sched
// Brief   : Arbitrates duty-cycle requests and slew-limits the shared PWM duty.
//           Define PWM_SCHED_FIXED_PRIO_EN for fixed-priority arbitration.
// Revision: 1.0
// ============================================================================
module pwm_duty_sched #(
  parameter int NREQ        = 2,
  parameter int PERIOD_CLKS = 256,
  parameter int STEP        = 1
) (
  input  logic                                   clk,
  input  logic                                   clr,
  input  logic [NREQ-1:0]                        req_valid,
  input  logic [8*NREQ-1:0]                      req_duty,
  output logic [NREQ-1:0]                        req_ready,
  output logic [7:0]                             duty_cycle,
  output logic                                   busy,
  output logic                                   done,
  output logic [((NREQ > 1) ? $clog2(NREQ) : 1)-1:0] grant_id,
  output logic                                   tick
);

  localparam int              c_IW   = (NREQ > 1) ? $clog2(NREQ) : 1;
  localparam int              c_CW   = $clog2(PERIOD_CLKS);
  localparam logic [c_CW-1:0] c_LAST = c_CW'(PERIOD_CLKS - 1);
  localparam logic [8:0]      c_STEP = 9'(STEP);

  typedef enum logic [0:0] {
    S_IDLE = 1'b0,
    S_RAMP = 1'b1
  } state_t;

  state_t          r_state;
  state_t          w_state_nxt;
  logic [c_CW-1:0] r_cnt;
  logic [7:0]      r_duty;
  logic [7:0]      r_target;
  logic            r_busy;
  logic            r_done;
  logic [c_IW-1:0] r_grant;

  logic            w_tick;
  logic            w_gnt_any;
  logic [c_IW-1:0] w_gnt_idx;
  logic            w_xfer;
  logic [7:0]      w_req_duty;
  logic            w_up;
  logic [8:0]      w_diff;
  logic [7:0]      w_step;
  logic [7:0]      w_next_duty;

  // Free-running period counter; explicit wrap keeps non-power-of-two periods exact.
  always_ff @(posedge clk) begin
    if (clr) begin
      r_cnt <= '0;
    end else if (w_tick) begin
      r_cnt <= '0;
    end else begin
      r_cnt <= r_cnt + 1'b1;
    end
  end

  assign w_tick = (r_cnt == c_LAST);

  function automatic logic [c_IW-1:0] f_wrap(input int v);
    return c_IW'((v >= NREQ) ? (v - NREQ) : v);
  endfunction

`ifdef PWM_SCHED_FIXED_PRIO_EN
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[k]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = c_IW'(k);
      end
    end
  end
`else
  logic [c_IW-1:0] r_rr;

  // Scan downward so the requester closest to the pointer is assigned last and wins.
  always_comb begin
    w_gnt_any = 1'b0;
    w_gnt_idx = '0;
    for (int k = NREQ - 1; k >= 0; k--) begin
      if (req_valid[f_wrap(int'(r_rr) + k)]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = f_wrap(int'(r_rr) + k);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_rr <= '0;
    end else if (w_xfer) begin
      r_rr <= f_wrap(int'(w_gnt_idx) + 1);
    end
  end
`endif

  assign w_xfer     = !clr && (r_state == S_IDLE) && w_gnt_any;
  assign w_req_duty = req_duty[8*int'(w_gnt_idx) +: 8];

  always_comb begin
    req_ready = '0;
    if (w_xfer) begin
      req_ready[w_gnt_idx] = 1'b1;
    end
  end

  // Slew step: 9-bit distance clamped to STEP, so the update never overshoots or wraps.
  assign w_up        = (r_target > r_duty);
  assign w_diff      = w_up ? ({1'b0, r_target} - {1'b0, r_duty})
                            : ({1'b0, r_duty} - {1'b0, r_target});
  assign w_step      = (w_diff < c_STEP) ? w_diff[7:0] : c_STEP[7:0];
  assign w_next_duty = w_up ? (r_duty + w_step) : (r_duty - w_step);

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      S_IDLE: begin
        if (w_xfer && (w_req_duty != r_duty)) begin
          w_state_nxt = S_RAMP;
        end
      end
      S_RAMP: begin
        if (w_tick && (w_next_duty == r_target)) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  always_ff @(posedge clk) begin
    if (clr) begin
      r_duty   <= '0;
      r_target <= '0;
      r_busy   <= 1'b0;
      r_done   <= 1'b0;
      r_grant  <= '0;
    end else begin
      r_done <= 1'b0;
      case (r_state)
        S_IDLE: begin
          if (w_xfer) begin
            r_target <= w_req_duty;
            r_grant  <= w_gnt_idx;
            if (w_req_duty == r_duty) begin
              r_done <= 1'b1;
            end else begin
              r_busy <= 1'b1;
            end
          end
        end
        S_RAMP: begin
          if (w_tick) begin
            r_duty <= w_next_duty;
            if (w_next_duty == r_target) begin
              r_busy <= 1'b0;
              r_done <= 1'b1;
            end
          end
        end
        default: r_busy <= 1'b0;
      endcase
    end
  end

  assign duty_cycle = r_duty;
  assign busy       = r_busy;
  assign done       = r_done;
  assign grant_id   = r_grant;
  assign tick       = w_tick;

endmodule
`default_nettype wire
